// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execution unit: opcode encodings and FSM states.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_exec_s_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH cycles after start; product is the low DATA_WIDTH bits.
module mul_seq_s #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  active_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] mcand_reg;
  logic [DATA_WIDTH-1:0] mplier_reg;
  logic [DATA_WIDTH-1:0] acc_reg;
  logic [DATA_WIDTH-1:0] addend;

  // product/done reflect the accumulator after the current iteration, so the
  // final sum is visible during the last iteration cycle.
  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign product = acc_reg + addend;
  assign done    = active_reg && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      cnt_reg    <= '0;
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      acc_reg    <= '0;
    end else if (active_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (done) begin
        active_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_s.sv
// Execution unit: single-cycle ALU ops write back one cycle after accept;
// MUL runs the iterative multiplier before its write-back cycle.
module alu_exec_s
  import alu_exec_pkg::*;
#(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DIR_WIDTH-1:0]  rd,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  write_en,
  output logic [DIR_WIDTH-1:0]  write_dir,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy
);

  state_t                state_reg;
  logic [DIR_WIDTH-1:0]  rd_reg;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_writes;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [SHAMT_W-1:0]    shamt;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign shamt     = rs2_data[SHAMT_W-1:0];

  // Operands are consumed directly at accept, so later input changes cannot
  // affect a single-cycle op; MUL operands are captured by the multiplier.
  always_comb begin
    alu_result = '0;
    alu_writes = 1'b1;
    case (op_t'(op))
      OP_ADD:  alu_result = rs1_data + rs2_data;
      OP_SUB:  alu_result = rs1_data - rs2_data;
      OP_AND:  alu_result = rs1_data & rs2_data;
      OP_OR:   alu_result = rs1_data | rs2_data;
      OP_XOR:  alu_result = rs1_data ^ rs2_data;
      OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
      OP_SLL:  alu_result = rs1_data << shamt;
      OP_SRL:  alu_result = rs1_data >> shamt;
      default: alu_writes = 1'b0;
    endcase
  end

  mul_seq_s #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (mul_start),
    .multiplicand(rs1_data),
    .multiplier  (rs2_data),
    .done        (mul_done),
    .product     (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg  <= IDLE;
      rd_reg     <= '0;
      write_en   <= 1'b0;
      write_dir  <= '0;
      write_data <= '0;
    end else begin
      write_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rd_reg <= rd;
            if (op == OP_MUL) begin
              state_reg <= MUL;
            end else begin
              // Reserved ops and rd==0 still take the WB slot, just without a strobe.
              state_reg  <= WB;
              write_en   <= alu_writes && (rd != '0);
              write_dir  <= rd;
              write_data <= alu_result;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            state_reg  <= WB;
            write_en   <= (rd_reg != '0);
            write_dir  <= rd_reg;
            write_data <= mul_product;
          end
        end
        WB:      state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_s.sv
// Directed-vector bench for alu_exec_s with hand-computed expected results.
module tb_alu_exec_s;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        write_en;
  logic [4:0]  write_dir;
  logic [31:0] write_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_s #(.DIR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .write_en  (write_en),
    .write_dir (write_dir),
    .write_data(write_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, hold junk on the inputs while busy, then check the single
  // write-back cycle at accept+lat and the return to idle one cycle later.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_we, input logic [31:0] exp_data, input int lat);
    check_eq({tag, ".ready_in"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; rd = r; rs1_data = a; rs2_data = b;
    step();
    in_valid = 1'b1; op = 4'd0; rd = 5'd31; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678;
    for (int i = 1; i < lat; i++) begin
      check_eq({tag, ".busy_wait"}, {30'd0, in_ready, write_en}, 32'd0);
      step();
    end
    check_eq({tag, ".wb_ready"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, ".wb_we"}, {31'd0, write_en}, {31'd0, exp_we});
    if (exp_we) begin
      check_eq({tag, ".wb_dir"}, {27'd0, write_dir}, {27'd0, r});
      check_eq({tag, ".wb_data"}, write_data, exp_data);
    end
    in_valid = 1'b0;
    step();
    check_eq({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, ".idle_we"}, {31'd0, write_en}, 32'd0);
    $display("op %s: op=%0h rd=%0d a=0x%08h b=0x%08h -> we=%0b data=0x%08h", tag, o, r, a, b,
             exp_we, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_we;
    arst_n = 1'b0; in_valid = 1'b0; op = 4'd0; rd = 5'd0; rs1_data = '0; rs2_data = '0;
    step();
    step();
    check_eq("rst.we",   {31'd0, write_en}, 32'd0);
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_eq("rst.dir",  {27'd0, write_dir}, 32'd0);
    check_eq("rst.data", write_data, 32'd0);
    arst_n = 1'b1;
    check_eq("rst.ready", {31'd0, in_ready}, 32'd1);
    step();

    run_op("add",      4'd0, 5'd3, 32'd5,          32'd8,          1'b1, 32'd13,         1);
    run_op("add_wrap", 4'd0, 5'd2, 32'hFFFF_FFFF,  32'd2,          1'b1, 32'd1,          1);
    run_op("sub",      4'd1, 5'd4, 32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF,  1);
    run_op("and",      4'd2, 5'd6, 32'hFF00_FF00,  32'h0FF0_0FF0,  1'b1, 32'h0F00_0F00,  1);
    run_op("or",       4'd3, 5'd6, 32'h0000_00F0,  32'h0000_0F00,  1'b1, 32'h0000_0FF0,  1);
    run_op("xor",      4'd4, 5'd6, 32'hF0F0_00FF,  32'h0FF0_0F0F,  1'b1, 32'hFF00_0FF0,  1);
    run_op("slt_neg",  4'd5, 5'd5, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'd1,          1);
    run_op("slt_pos",  4'd5, 5'd5, 32'd1,          32'hFFFF_FFFF,  1'b1, 32'd0,          1);
    run_op("sll",      4'd6, 5'd9, 32'd1,          32'h0000_0025,  1'b1, 32'd32,         1);
    run_op("srl",      4'd7, 5'd9, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd1,          1);
    run_op("mul",      4'd8, 5'd7, 32'd21,         32'd34,         1'b1, 32'd714,        33);
    run_op("mul_wrap", 4'd8, 5'd8, 32'hFFFF_FFFF,  32'd2,          1'b1, 32'hFFFF_FFFE,  33);
    run_op("add_rd0",  4'd0, 5'd0, 32'd5,          32'd8,          1'b0, 32'd0,          1);
    run_op("mul_rd0",  4'd8, 5'd0, 32'd3,          32'd3,          1'b0, 32'd0,          33);
    run_op("reserved", 4'hF, 5'd9, 32'd5,          32'd8,          1'b0, 32'd0,          1);

    // Reset in the middle of a multiply must abort it without a write.
    check_eq("abort.ready_in", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = 4'd8; rd = 5'd10; rs1_data = 32'd6; rs2_data = 32'd7;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    check_eq("abort.busy", {31'd0, busy}, 32'd1);
    arst_n = 1'b0;
    step();
    check_eq("abort.rst_we",   {31'd0, write_en}, 32'd0);
    check_eq("abort.rst_busy", {31'd0, busy}, 32'd0);
    check_eq("abort.rst_data", write_data, 32'd0);
    arst_n = 1'b1;
    check_eq("abort.ready", {31'd0, in_ready}, 32'd1);
    saw_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (write_en) saw_we = 1'b1;
    end
    check_eq("abort.no_write", {31'd0, saw_we}, 32'd0);
    $display("op abort: MUL reset at cycle 10, no write-back");
    run_op("add_after", 4'd0, 5'd1, 32'd1, 32'd1, 1'b1, 32'd2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_s.md
ALU_EXEC_S -- requirements
Module: alu_exec_s

Interface
REQ-001 Parameter DIR_WIDTH, default 5, SHALL set the register-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL indicate that an operation request is present.
REQ-006 in_ready  output  1  SHALL indicate that the unit accepts a request this cycle.
REQ-007 op  input  4  SHALL carry the opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, MUL=8; all other values are reserved.
REQ-008 rd  input  DIR_WIDTH  SHALL carry the destination register address.
REQ-009 rs1_data  input  DATA_WIDTH  SHALL carry operand A, driven from the register bank read_data1.
REQ-010 rs2_data  input  DATA_WIDTH  SHALL carry operand B, driven from the register bank read_data2.
REQ-011 write_en  output  1  SHALL be the write strobe to the register bank.
REQ-012 write_dir  output  DIR_WIDTH  SHALL be the write address to the register bank.
REQ-013 write_data  output  DATA_WIDTH  SHALL be the write data to the register bank.
REQ-014 busy  output  1  SHALL be high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, MUL and WB.
REQ-016 in_ready SHALL equal (state==IDLE); a request is accepted when in_valid && in_ready.
REQ-017 On accept, the unit SHALL capture op, rd, rs1_data and rs2_data; later input changes SHALL have no effect on that operation.
REQ-018 An accepted non-MUL op in cycle N SHALL move the FSM to WB; write_en=1 in cycle N+1 with the result; the FSM SHALL return to IDLE at N+2.
REQ-019 An accepted MUL in cycle N SHALL run MUL for exactly DATA_WIDTH cycles (N+1..N+DATA_WIDTH), one shift-add iteration per cycle, counter 0..DATA_WIDTH-1.
REQ-020 After the MUL cycles the FSM SHALL enter WB at cycle N+DATA_WIDTH+1.
REQ-021 The MUL result SHALL be the low DATA_WIDTH bits of the unsigned product.
REQ-022 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH with no overflow flag.
REQ-023 SLT SHALL compare signed and return 1 or 0, zero-extended.
REQ-024 SLL/SRL SHALL be logical shifts, with the shift amount taken from rs2_data[4:0] only.
REQ-025 write_en SHALL be high only in WB, for exactly one cycle per accepted operation.
REQ-026 write_dir and write_data SHALL hold their last values outside WB.
REQ-027 If rd==0, write_en SHALL stay 0 in WB; timing SHALL be unchanged.
REQ-028 A reserved op SHALL complete through WB with write_en=0 (NOP timing as in REQ-018).
REQ-029 in_valid while busy SHALL be ignored, with no queuing.

Reset
REQ-030 While arst_n=0 at a clock edge: state=IDLE, write_en=0, write_dir=0, write_data=0, busy=0, MUL counter=0.
REQ-031 A reset asserted during MUL or WB SHALL abort the operation, with no write issued.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 Package alu_exec_pkg SHALL hold the op_t enum (REQ-007 encodings) and the state_t enum (IDLE, MUL, WB).
REQ-034 The iterative multiplier SHALL be the sub-module mul_seq_s, with ports start, multiplicand, multiplier, done and product.
REQ-035 The single-cycle ALU operations SHALL be inside alu_exec_s.

Verification
REQ-036 Reset, then ADD rs1=5, rs2=8, rd=3 -> write_en=1, write_dir=3, write_data=13 one cycle after accept.
REQ-037 SUB rs1=0, rs2=1, rd=4 -> write_data=32'hFFFF_FFFF; SLT rs1=32'hFFFF_FFFF, rs2=1 -> write_data=1.
REQ-038 MUL rs1=21, rs2=34, rd=7 -> in_ready=0 for 33 cycles after accept; write_data=714 at accept+33.
REQ-039 MUL rs1=32'hFFFF_FFFF, rs2=2 -> write_data=32'hFFFF_FFFE.
REQ-040 ADD with rd=0 -> write_en=0 throughout; OP=4'hF -> write_en=0, in_ready back high at accept+2.
REQ-041 Reset at MUL cycle 10 -> no write_en pulse; in_ready=1 after release; the next ADD 1+1 gives 2.
